// File: rtl/ppu_pkg.sv
// Shared types and defaults for the fixed-point accumulate path.
package ppu_pkg;

  localparam int unsigned FX_M_DEFAULT         = 32;
  localparam int unsigned FX_N_DEFAULT         = 64;
  localparam int unsigned FX_ACC_GUARD_DEFAULT = 8;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACCUM,
    ACC_HOLD
  } fx_acc_state_e;

endpackage

// File: rtl/fixed_tc_to_sm.sv
// Two's-complement ACC_W value to saturated {sign, FX_N} sign-magnitude.
// A zero input always yields {0, 0}.
module fixed_tc_to_sm #(
  parameter int unsigned FX_N  = 64,
  parameter int unsigned ACC_W = 73
) (
  input  logic [ACC_W-1:0] acc,
  output logic [FX_N:0]    sm_c,
  output logic             sat_c
);

  logic             neg;
  logic [ACC_W-1:0] mag;

  always_comb begin
    neg   = acc[ACC_W-1];
    mag   = neg ? (ACC_W'(0) - acc) : acc;
    // The most negative value negates to itself; its top bit still forces saturation.
    sat_c = |mag[ACC_W-1:FX_N];
    sm_c  = {neg, sat_c ? {FX_N{1'b1}} : mag[FX_N-1:0]};
  end

endmodule

// File: rtl/fixed_accumulator.sv
// Quire-style accumulator: sums sign-magnitude Fx<FX_M,FX_N> terms in a wide
// two's-complement register and emits one saturated sign-magnitude result per stream.
module fixed_accumulator
  import ppu_pkg::*;
#(
  parameter int unsigned FX_M      = FX_M_DEFAULT,
  parameter int unsigned FX_N      = FX_N_DEFAULT,
  parameter int unsigned ACC_GUARD = FX_ACC_GUARD_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [FX_N:0] fixed_i,
  input  logic          last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [FX_N:0] fixed_o,
  output logic          overflow_o,
  output logic          busy_o
);

  localparam int unsigned ACC_W = 1 + FX_N + ACC_GUARD;

  if (FX_M > FX_N) begin : g_bad_format
    $error("fixed_accumulator: FX_M must not exceed FX_N");
  end

  fx_acc_state_e    state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [FX_N:0]    fixed_d;
  logic             ovf_out_d;
  logic             in_ready_d, out_valid_d, busy_d;

  logic [ACC_W-1:0] mag_ext_c, term_c, sum_c;
  logic             add_ovf_c, ovf_next_c;
  logic [FX_N:0]    conv_sm_c;
  logic             conv_sat_c;

  // Signed term and running sum; wrap is detected from operand/result signs.
  always_comb begin
    mag_ext_c  = ACC_W'(fixed_i[FX_N-1:0]);
    term_c     = fixed_i[FX_N] ? (ACC_W'(0) - mag_ext_c) : mag_ext_c;
    sum_c      = acc_q + term_c;
    add_ovf_c  = (acc_q[ACC_W-1] == term_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
    ovf_next_c = ovf_q | add_ovf_c;
  end

  fixed_tc_to_sm #(
    .FX_N  (FX_N),
    .ACC_W (ACC_W)
  ) u_conv (
    .acc   (sum_c),
    .sm_c  (conv_sm_c),
    .sat_c (conv_sat_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    fixed_d   = fixed_o;
    ovf_out_d = overflow_o;

    unique case (state_q)
      ACC_IDLE: begin
        if (start_i) begin
          state_d = ACC_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACC_ACCUM: begin
        if (start_i) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid_i) begin
          acc_d = sum_c;
          ovf_d = ovf_next_c;
          if (last_i) begin
            state_d   = ACC_HOLD;
            fixed_d   = (conv_sat_c | ovf_next_c) ? {conv_sm_c[FX_N], {FX_N{1'b1}}} : conv_sm_c;
            ovf_out_d = conv_sat_c | ovf_next_c;
          end
        end
      end
      ACC_HOLD: begin
        if (out_ready_i) begin
          state_d = start_i ? ACC_ACCUM : ACC_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC_IDLE;
    endcase

    in_ready_d  = (state_d == ACC_ACCUM);
    out_valid_d = (state_d == ACC_HOLD);
    busy_d      = (state_d != ACC_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACC_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      fixed_o     <= '0;
      overflow_o  <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      fixed_o     <= fixed_d;
      overflow_o  <= ovf_out_d;
      in_ready_o  <= in_ready_d;
      out_valid_o <= out_valid_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fixed_accumulator.sv
// Self-checking bench for fixed_accumulator (FX_M=32, FX_N=64) with a wide-integer reference sum.
module tb_fixed_accumulator;

  localparam int unsigned N = 64;
  localparam logic [N-1:0] ONE = 64'h1_0000_0000;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i, in_valid_i, in_ready_o, last_i;
  logic         out_valid_o, out_ready_i, overflow_o, busy_o;
  logic [N:0]   fixed_i, fixed_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [127:0] msum;

  fixed_accumulator #(.FX_M(32), .FX_N(64), .ACC_GUARD(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .fixed_i(fixed_i), .last_i(last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .fixed_o(fixed_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic signed [127:0] sval(input logic s, input logic [N-1:0] m);
    logic signed [127:0] v;
    v = $signed({64'd0, m});
    return s ? -v : v;
  endfunction

  // Expected {overflow, sign, magnitude} for an exact integer sum.
  function automatic logic [N+1:0] expect_of(input logic signed [127:0] s);
    logic [127:0] a;
    a = (s < 0) ? 128'(-s) : 128'(s);
    if (a >= (128'd1 << 64)) return {1'b1, (s < 0), {N{1'b1}}};
    return {1'b0, (s < 0), a[N-1:0]};
  endfunction

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    msum = '0;
  endtask

  task automatic send(input logic s, input logic [N-1:0] m, input logic l);
    in_valid_i = 1'b1;
    fixed_i    = {s, m};
    last_i     = l;
    tick();
    in_valid_i = 1'b0;
    last_i     = 1'b0;
    msum       = msum + sval(s, m);
  endtask

  // Wait (bounded) for a result, capture it, then handshake after dly stalled cycles.
  task automatic drain(input int dly, output logic [N:0] f, output logic ov, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    f  = fixed_o;
    ov = overflow_o;
    for (int i = 0; i < dly; i++) tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if ({in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b ovf=%b fx=%h, want all 0",
               in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o);
    end
    send(1'b0, ONE, 1'b1);
    n_cmp++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_ignores_input: got rdy/vld/busy=%b want 000", {in_ready_o, out_valid_o, busy_o});
    end
  endtask

  task automatic test_basic();
    do_start();
    n_cmp++;
    if ({in_ready_o, busy_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL accum_entry: got rdy/busy=%b want 11", {in_ready_o, busy_o});
    end
    send(1'b0, ONE, 1'b0);
    send(1'b0, 2 * ONE, 1'b1);
    n_cmp++;
    if ({out_valid_o, in_ready_o, overflow_o, fixed_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 3 * ONE}) begin
      n_bad++;
      $display("FAIL basic_sum: got vld=%b rdy=%b ovf=%b fx=%h want vld=1 rdy=0 ovf=0 fx=%h",
               out_valid_o, in_ready_o, overflow_o, fixed_o, {1'b0, 3 * ONE});
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    n_cmp++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_release: got vld/busy=%b want 00", {out_valid_o, busy_o});
    end
  endtask

  task automatic test_signs();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    send(1'b0, ONE, 1'b0);
    send(1'b1, 3 * ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {1'b1, 1'b0, 1'b1, 2 * ONE}) begin
      n_bad++;
      $display("FAIL neg_sum: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=%h", ok, ov, f, {1'b1, 2 * ONE});
    end
    do_start();
    send(1'b0, 2 * ONE, 1'b0);
    send(1'b1, 2 * ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 65'd0}) begin
      n_bad++;
      $display("FAIL zero_sum: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=0", ok, ov, f);
    end
    do_start();
    send(1'b1, 64'd0, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 65'd0}) begin
      n_bad++;
      $display("FAIL neg_zero: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=0", ok, ov, f);
    end
  endtask

  task automatic test_saturation();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    send(1'b0, {N{1'b1}}, 1'b0);
    send(1'b0, {N{1'b1}}, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b11, 1'b0, {N{1'b1}}}) begin
      n_bad++;
      $display("FAIL sat_pos: got ok=%b ovf=%b fx=%h want ok=1 ovf=1 fx=%h", ok, ov, f, {1'b0, {N{1'b1}}});
    end
    do_start();
    send(1'b1, {N{1'b1}}, 1'b0);
    send(1'b1, {N{1'b1}}, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b11, 1'b1, {N{1'b1}}}) begin
      n_bad++;
      $display("FAIL sat_neg: got ok=%b ovf=%b fx=%h want ok=1 ovf=1 fx=%h", ok, ov, f, {1'b1, {N{1'b1}}});
    end
  endtask

  task automatic test_empty_stream();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if ({out_valid_o, busy_o, in_ready_o} !== 3'b011) begin
      n_bad++;
      $display("FAIL empty_stream: got vld/busy/rdy=%b want 011", {out_valid_o, busy_o, in_ready_o});
    end
    do_start();
    send(1'b0, ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 1'b0, ONE}) begin
      n_bad++;
      $display("FAIL after_empty: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=%h", ok, ov, f, {1'b0, ONE});
    end
  endtask

  task automatic test_backpressure();
    logic [N:0] held;
    int bad;
    do_start();
    send(1'b1, 5 * ONE, 1'b0);
    send(1'b0, ONE, 1'b1);
    held = {1'b1, 4 * ONE};
    bad  = 0;
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2);
      tick();
      start_i = 1'b0;
      if (!(out_valid_o === 1'b1 && in_ready_o === 1'b0 && fixed_o === held && busy_o === 1'b1)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d bad cycles, last fx=%h vld=%b rdy=%b want 0 bad fx=%h",
               bad, fixed_o, out_valid_o, in_ready_o, held);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    n_cmp++;
    if ({out_valid_o, busy_o, in_ready_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL backpressure_release: got vld/busy/rdy=%b want 000", {out_valid_o, busy_o, in_ready_o});
    end
  endtask

  task automatic test_start_priority();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    send(1'b0, ONE, 1'b0);
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    fixed_i    = {1'b0, 5 * ONE};
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    msum       = '0;
    send(1'b0, 2 * ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 1'b0, 2 * ONE}) begin
      n_bad++;
      $display("FAIL start_priority: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=%h", ok, ov, f, {1'b0, 2 * ONE});
    end
  endtask

  task automatic test_back_to_back();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    send(1'b0, 7 * ONE, 1'b1);
    out_ready_i = 1'b1;
    start_i     = 1'b1;
    tick();
    out_ready_i = 1'b0;
    start_i     = 1'b0;
    msum        = '0;
    n_cmp++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL b2b_restart: got rdy/vld/busy=%b want 101", {in_ready_o, out_valid_o, busy_o});
    end
    send(1'b0, ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 1'b0, ONE}) begin
      n_bad++;
      $display("FAIL b2b_cleared: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=%h", ok, ov, f, {1'b0, ONE});
    end
  endtask

  task automatic test_reset_mid();
    logic [N:0] f;
    logic ov, ok;
    do_start();
    send(1'b0, ONE, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if ({in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_in_accum: got rdy=%b vld=%b busy=%b ovf=%b fx=%h want all 0",
               in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o);
    end
    do_start();
    send(1'b0, ONE, 1'b0);
    send(1'b0, 2 * ONE, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if ({in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_in_hold: got rdy=%b vld=%b busy=%b ovf=%b fx=%h want all 0",
               in_ready_o, out_valid_o, busy_o, overflow_o, fixed_o);
    end
    do_start();
    send(1'b0, ONE, 1'b1);
    drain(0, f, ov, ok);
    n_cmp++;
    if ({ok, ov, f} !== {2'b10, 1'b0, ONE}) begin
      n_bad++;
      $display("FAIL reset_fresh: got ok=%b ovf=%b fx=%h want ok=1 ovf=0 fx=%h", ok, ov, f, {1'b0, ONE});
    end
  endtask

  task automatic test_random();
    logic [N:0] f;
    logic ov, ok, s;
    logic [N-1:0] m;
    logic [N+1:0] exp;
    int nterms;
    for (int k = 0; k < 40; k++) begin
      do_start();
      nterms = $urandom_range(1, 6);
      for (int t = 0; t < nterms; t++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          fixed_i = {$urandom, $urandom, 1'b0};
          tick();
        end
        s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) m = {$urandom, $urandom};
        else m = 64'($urandom_range(0, 4000)) << 28;
        send(s, m, (t == nterms - 1));
      end
      exp = expect_of(msum);
      drain($urandom_range(0, 3), f, ov, ok);
      n_cmp++;
      if ({ok, ov, f} !== {1'b1, exp}) begin
        n_bad++;
        $display("FAIL random_stream%0d: got ok=%b ovf=%b fx=%h want ok=1 ovf=%b fx=%h",
                 k, ok, ov, f, exp[N+1], exp[N:0]);
      end
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    last_i      = 1'b0;
    out_ready_i = 1'b0;
    fixed_i     = '0;
    msum        = '0;
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_empty_stream();
    test_backpressure();
    test_start_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
